// File: rtl/mfp_pmod_spi_pkg.sv
// Shared types and helpers for the Pmod SPI read arbiter and its sub-blocks.
package mfp_pmod_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int DEF_SCK_HALF = 8;
  localparam int DEF_CS_SETUP = 8;
  localparam int DEF_CS_GAP   = 16;

  // Ceiling log2, never less than 1 so it is always usable as a vector width.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mfp_pmod_spi_read_arbiter_if.sv
// Client request/ack port plus Pmod SPI pins of the shared read bus.
interface mfp_pmod_spi_read_arbiter_if #(
  parameter int N_CLIENTS = 2,
  parameter int NUM_BITS  = 16
);
  import mfp_pmod_spi_pkg::*;

  // Handshake: a client raises req[i] and holds it; the arbiter answers with a
  // single-cycle ack[i] carrying rdata in the same cycle. req is only looked at
  // in IDLE, so dropping it mid-frame neither aborts nor suppresses the ack.
  logic [N_CLIENTS-1:0] req;
  logic [N_CLIENTS-1:0] ack;
  logic [NUM_BITS-1:0]  rdata;
  logic                 busy;
  logic [N_CLIENTS-1:0] cs_n;
  logic                 sck;
  logic                 sdo;
  state_t               state;

  modport master (
    input  req, sdo,
    output ack, rdata, busy, cs_n, sck, state
  );

  modport slave (
    output req, sdo,
    input  ack, rdata, busy, cs_n, sck, state
  );

endinterface

// File: rtl/mfp_rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from ptr+1.
module mfp_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          valid
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    valid = 1'b0;
    for (int i = 1; i <= N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        grant = PW'(j);
      end
    end
  end

endmodule

// File: rtl/mfp_pmod_spi_read_arbiter.sv
// Round-robin sharing of one read-only SPI bus between N_CLIENTS requesters;
// sequences cs setup, NUM_BITS sck periods and an inter-frame gap.
module mfp_pmod_spi_read_arbiter
  import mfp_pmod_spi_pkg::*;
#(
  parameter int N_CLIENTS = 2,
  parameter int NUM_BITS  = 16,
  parameter int SCK_HALF  = DEF_SCK_HALF,
  parameter int CS_SETUP  = DEF_CS_SETUP,
  parameter int CS_GAP    = DEF_CS_GAP
) (
  input logic                        clock,
  input logic                        reset_n,
  mfp_pmod_spi_read_arbiter_if.master bus
);

  localparam int PW = clog2(N_CLIENTS);
  localparam int CW = clog2(max3(SCK_HALF, CS_SETUP, CS_GAP) + 1);
  localparam int BW = clog2(NUM_BITS + 1);

  localparam logic [CW-1:0]        LD_HALF  = CW'(SCK_HALF - 1);
  localparam logic [CW-1:0]        LD_SETUP = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0]        LD_GAP   = CW'(CS_GAP - 1);
  localparam logic [BW-1:0]        LD_BITS  = BW'(NUM_BITS - 1);
  localparam logic [PW-1:0]        PTR_RST  = PW'(N_CLIENTS - 1);
  localparam logic [N_CLIENTS-1:0] ONE      = N_CLIENTS'(1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 sck_q, sck_d;
  logic [NUM_BITS-1:0]  shift_q, shift_d;
  logic [NUM_BITS-1:0]  rdata_q, rdata_d;
  logic [N_CLIENTS-1:0] ack_q, ack_d;
  logic [N_CLIENTS-1:0] cs_n_q, cs_n_d;
  logic                 busy_q, busy_d;
  logic [PW-1:0]        grant_q, grant_d;
  logic [PW-1:0]        ptr_q, ptr_d;

  logic [PW-1:0]        arb_grant;
  logic                 arb_valid;

  mfp_rr_arbiter #(
    .N  (N_CLIENTS),
    .PW (PW)
  ) u_rr_arbiter (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b1;
      shift_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      cs_n_q  <= '1;
      busy_q  <= 1'b0;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_SETUP;
          grant_d = arb_grant;
          ptr_d   = arb_grant;
          cs_n_d  = ~(ONE << arb_grant);
          cnt_d   = LD_SETUP;
          busy_d  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_SHIFT;
          sck_d   = 1'b0;
          cnt_d   = LD_HALF;
          bit_d   = LD_BITS;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SHIFT: begin
        // sck_q doubles as the half-period phase: 0 = low half, 1 = high half.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!sck_q) begin
          shift_d = (shift_q << 1) | NUM_BITS'(bus.sdo);
          sck_d   = 1'b1;
          cnt_d   = LD_HALF;
        end else if (bit_q == '0) begin
          state_d = ST_GAP;
          cs_n_d  = '1;
          rdata_d = shift_q;
          ack_d   = ONE << grant_q;
          cnt_d   = LD_GAP;
        end else begin
          sck_d = 1'b0;
          bit_d = bit_q - BW'(1);
          cnt_d = LD_HALF;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign bus.cs_n  = cs_n_q;
  assign bus.sck   = sck_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_mfp_pmod_spi_read_arbiter.sv
// Bench for mfp_pmod_spi_read_arbiter: SPI device model, bus monitor and a
// scoreboard of expected {client, word} results.
module tb_mfp_pmod_spi_read_arbiter;
  import mfp_pmod_spi_pkg::*;

  localparam int N  = 2;
  localparam int NB = 16;
  localparam int SH = 2;
  localparam int CSU = 2;
  localparam int CG = 4;
  localparam int W  = NB + 1;
  localparam int FRAME_LOW = CSU + 2 * SH * NB;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  mfp_pmod_spi_read_arbiter_if #(.N_CLIENTS(N), .NUM_BITS(NB)) bus ();

  mfp_pmod_spi_read_arbiter #(
    .N_CLIENTS (N),
    .NUM_BITS  (NB),
    .SCK_HALF  (SH),
    .CS_SETUP  (CSU),
    .CS_GAP    (CG)
  ) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  int            n_vec  = 0;
  int            n_miss = 0;
  logic [NB-1:0] dev_pat [N];

  // ---------------- SPI device model: next bit on each sck fall ----------------
  int   dev_idx      = 0;
  logic dev_prev_sck = 1'b1;
  always @(negedge clock) begin
    if (bus.cs_n === 2'b11) begin
      dev_idx = 0;
    end else if (dev_prev_sck === 1'b1 && bus.sck === 1'b0 && dev_idx < NB) begin
      bus.sdo = dev_pat[bus.cs_n[0] ? 1 : 0][NB-1-dev_idx];
      dev_idx++;
    end
    dev_prev_sck = bus.sck;
  end

  // ---------------- bus monitor ----------------
  int             low_cnt [N];
  int             last_low [N];
  int             rise_cnt = 0;
  int             last_rise = 0;
  int             gap_run = 0;
  int             min_gap = 1000;
  bit             gap_open = 1'b0;
  bit             both_low = 1'b0;
  bit             cs1_seen = 1'b0;
  logic [N-1:0]   mon_prev_cs = '1;
  logic           mon_prev_sck = 1'b1;
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (bus.cs_n[i] === 1'b0) low_cnt[i]++;
      else if (mon_prev_cs[i] === 1'b0) begin
        last_low[i] = low_cnt[i];
        low_cnt[i]  = 0;
      end
    end
    if (bus.cs_n !== 2'b11 && mon_prev_sck === 1'b0 && bus.sck === 1'b1) rise_cnt++;
    if (bus.cs_n === 2'b11) begin
      if (mon_prev_cs !== 2'b11) begin
        last_rise = rise_cnt;
        rise_cnt  = 0;
        gap_open  = 1'b1;
        gap_run   = 0;
      end
      if (gap_open) gap_run++;
    end else if (gap_open && mon_prev_cs === 2'b11) begin
      if (gap_run < min_gap) min_gap = gap_run;
      gap_open = 1'b0;
    end
    if (bus.cs_n === 2'b00) both_low = 1'b1;
    if (bus.cs_n[1] === 1'b0) cs1_seen = 1'b1;
    mon_prev_cs  = bus.cs_n;
    mon_prev_sck = bus.sck;
  end

  // ---------------- driver helpers (no checking) ----------------
  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (bus.ack !== 2'b00) begin
        got = 1'b1;
        return;
      end
    end
  endtask

  task automatic pop_expected(output logic [W-1:0] e);
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    bus.req = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_vec++; if (bus.cs_n !== 2'b11) begin n_miss++; $display("FAIL reset_cs_n: got %b want 11", bus.cs_n); end
    n_vec++; if (bus.sck !== 1'b1) begin n_miss++; $display("FAIL reset_sck: got %b want 1", bus.sck); end
    n_vec++; if (bus.ack !== 2'b00) begin n_miss++; $display("FAIL reset_ack: got %b want 00", bus.ack); end
    n_vec++; if (bus.rdata !== 16'h0000) begin n_miss++; $display("FAIL reset_rdata: got %h want 0000", bus.rdata); end
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.state !== ST_IDLE) begin n_miss++; $display("FAIL reset_state: got %0d want %0d", bus.state, ST_IDLE); end
  endtask

  task automatic test_single_read;
    logic [W-1:0] e;
    bit got;
    dev_pat[0] = 16'hA5C3;
    cs1_seen = 1'b0;
    exp_q.push_back({1'b0, 16'hA5C3});
    @(negedge clock);
    bus.req = 2'b01;
    @(negedge clock);
    n_vec++; if (bus.cs_n !== 2'b10) begin n_miss++; $display("FAIL single_latency_cs_n: got %b want 10", bus.cs_n); end
    n_vec++; if (bus.busy !== 1'b1) begin n_miss++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    wait_ack(got);
    bus.req = 2'b00;
    pop_expected(e);
    n_vec++; if (!got) begin n_miss++; $display("FAIL single_ack_timeout: got none want ack"); end
    n_vec++; if (bus.ack !== (e[NB] ? 2'b10 : 2'b01)) begin n_miss++; $display("FAIL single_ack: got %b want %b", bus.ack, (e[NB] ? 2'b10 : 2'b01)); end
    n_vec++; if (bus.rdata !== e[NB-1:0]) begin n_miss++; $display("FAIL single_rdata: got %h want %h", bus.rdata, e[NB-1:0]); end
    @(negedge clock);
    n_vec++; if (bus.ack !== 2'b00) begin n_miss++; $display("FAIL single_ack_pulse: got %b want 00", bus.ack); end
    n_vec++; if (last_low[0] !== FRAME_LOW) begin n_miss++; $display("FAIL single_cs0_low_len: got %0d want %0d", last_low[0], FRAME_LOW); end
    n_vec++; if (last_rise !== NB) begin n_miss++; $display("FAIL single_sck_rises: got %0d want %0d", last_rise, NB); end
    n_vec++; if (cs1_seen !== 1'b0) begin n_miss++; $display("FAIL single_cs1_idle: got %b want 0", cs1_seen); end
    for (int c = 0; c < 20 && bus.busy !== 1'b0; c++) @(negedge clock);
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL single_busy_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_simultaneous;
    logic [W-1:0] e;
    bit got;
    dev_pat[0] = 16'h1234;
    dev_pat[1] = 16'hBEEF;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    both_low = 1'b0;
    min_gap  = 1000;
    gap_open = 1'b0;
    exp_q.push_back({1'b0, 16'h1234});
    exp_q.push_back({1'b1, 16'hBEEF});
    bus.req = 2'b11;
    for (int k = 0; k < 2; k++) begin
      wait_ack(got);
      pop_expected(e);
      n_vec++; if (!got || bus.ack !== (e[NB] ? 2'b10 : 2'b01)) begin n_miss++; $display("FAIL simul_ack_%0d: got %b want %b", k, bus.ack, (e[NB] ? 2'b10 : 2'b01)); end
      n_vec++; if (bus.rdata !== e[NB-1:0]) begin n_miss++; $display("FAIL simul_rdata_%0d: got %h want %h", k, bus.rdata, e[NB-1:0]); end
      bus.req = bus.req & ~bus.ack;
      if (!got) bus.req = 2'b00;
    end
    n_vec++; if (min_gap < CG) begin n_miss++; $display("FAIL simul_gap: got %0d want >= %0d", min_gap, CG); end
    n_vec++; if (both_low !== 1'b0) begin n_miss++; $display("FAIL simul_both_low: got %b want 0", both_low); end
  endtask

  task automatic test_fairness;
    logic [W-1:0] e;
    bit got;
    int k;
    dev_pat[0] = 16'h1357;
    dev_pat[1] = 16'h2468;
    for (int i = 0; i < 6; i++) exp_q.push_back({i[0], (i[0] ? 16'h2468 : 16'h1357)});
    @(negedge clock);
    bus.req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_ack(got);
      pop_expected(e);
      n_vec++; if (!got || bus.ack !== (e[NB] ? 2'b10 : 2'b01)) begin n_miss++; $display("FAIL fair_ack_%0d: got %b want %b", i, bus.ack, (e[NB] ? 2'b10 : 2'b01)); end
      n_vec++; if (bus.rdata !== e[NB-1:0]) begin n_miss++; $display("FAIL fair_rdata_%0d: got %h want %h", i, bus.rdata, e[NB-1:0]); end
      if (i == 5) bus.req = 2'b00;
      else begin
        k = 0;
        while (bus.cs_n === 2'b11 && k < 100) begin
          @(negedge clock);
          k++;
        end
        n_vec++; if (k !== CG + 1) begin n_miss++; $display("FAIL fair_regrant_%0d: got %0d cycles want %0d", i, k, CG + 1); end
      end
    end
    for (int c = 0; c < 20 && bus.busy !== 1'b0; c++) @(negedge clock);
  endtask

  task automatic test_abandoned;
    logic [W-1:0] e;
    bit got;
    int k;
    dev_pat[1] = 16'h0F0F;
    exp_q.push_back({1'b1, 16'h0F0F});
    @(negedge clock);
    bus.req = 2'b10;
    for (int c = 0; c < 100 && bus.state !== ST_SHIFT; c++) @(negedge clock);
    n_vec++; if (bus.state !== ST_SHIFT) begin n_miss++; $display("FAIL aband_shift: got %0d want %0d", bus.state, ST_SHIFT); end
    repeat (10) @(negedge clock);
    bus.req = 2'b00;
    wait_ack(got);
    pop_expected(e);
    n_vec++; if (!got || bus.ack !== 2'b10) begin n_miss++; $display("FAIL aband_ack: got %b want 10", bus.ack); end
    n_vec++; if (bus.rdata !== e[NB-1:0]) begin n_miss++; $display("FAIL aband_rdata: got %h want %h", bus.rdata, e[NB-1:0]); end
    k = 0;
    while (bus.busy !== 1'b0 && k < 100) begin
      @(negedge clock);
      k++;
    end
    n_vec++; if (k !== CG) begin n_miss++; $display("FAIL aband_busy_drop: got %0d cycles want %0d", k, CG); end
    n_vec++; if (bus.state !== ST_IDLE) begin n_miss++; $display("FAIL aband_idle: got %0d want %0d", bus.state, ST_IDLE); end
  endtask

  task automatic test_reset_mid_shift;
    logic [W-1:0] e;
    bit got;
    int acks;
    dev_pat[0] = 16'hC3C3;
    @(negedge clock);
    bus.req = 2'b01;
    for (int c = 0; c < 100 && bus.state !== ST_SHIFT; c++) @(negedge clock);
    repeat (5 * 2 * SH) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (bus.cs_n !== 2'b11) begin n_miss++; $display("FAIL rst_mid_cs_n: got %b want 11", bus.cs_n); end
    n_vec++; if (bus.sck !== 1'b1) begin n_miss++; $display("FAIL rst_mid_sck: got %b want 1", bus.sck); end
    n_vec++; if (bus.rdata !== 16'h0000) begin n_miss++; $display("FAIL rst_mid_rdata: got %h want 0000", bus.rdata); end
    n_vec++; if (bus.ack !== 2'b00) begin n_miss++; $display("FAIL rst_mid_ack: got %b want 00", bus.ack); end
    bus.req = 2'b00;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (bus.ack !== 2'b00) acks++;
    end
    n_vec++; if (acks !== 0) begin n_miss++; $display("FAIL rst_mid_no_ack: got %0d acks want 0", acks); end
    dev_pat[1] = 16'h00FF;
    exp_q.push_back({1'b1, 16'h00FF});
    bus.req = 2'b10;
    wait_ack(got);
    bus.req = 2'b00;
    pop_expected(e);
    n_vec++; if (!got || bus.ack !== 2'b10) begin n_miss++; $display("FAIL rst_mid_after_ack: got %b want 10", bus.ack); end
    n_vec++; if (bus.rdata !== e[NB-1:0]) begin n_miss++; $display("FAIL rst_mid_after_rdata: got %h want %h", bus.rdata, e[NB-1:0]); end
    for (int c = 0; c < 20 && bus.busy !== 1'b0; c++) @(negedge clock);
  endtask

  task automatic test_edge_patterns;
    logic [W-1:0] e;
    bit got;
    logic [NB-1:0] pats [2];
    pats[0] = 16'hFFFF;
    pats[1] = 16'h0000;
    for (int p = 0; p < 2; p++) begin
      dev_pat[0] = pats[p];
      exp_q.push_back({1'b0, pats[p]});
      @(negedge clock);
      bus.req = 2'b01;
      wait_ack(got);
      bus.req = 2'b00;
      pop_expected(e);
      n_vec++; if (!got || bus.ack !== 2'b01) begin n_miss++; $display("FAIL edge_ack_%0d: got %b want 01", p, bus.ack); end
      n_vec++; if (bus.rdata !== e[NB-1:0]) begin n_miss++; $display("FAIL edge_rdata_%0d: got %h want %h", p, bus.rdata, e[NB-1:0]); end
      for (int c = 0; c < 20 && bus.busy !== 1'b0; c++) @(negedge clock);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.req = '0;
    for (int i = 0; i < N; i++) begin
      low_cnt[i]  = 0;
      last_low[i] = 0;
      dev_pat[i]  = '0;
    end
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_abandoned();
    test_reset_mid_shift();
    test_edge_patterns();
    n_vec++; if (exp_q.size() != 0) begin n_miss++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
